// File: rtl/am2940_pkg.sv
// Shared types for the AM2940 DMA sequencing master: AM2940 instruction codes,
// control-register done modes and the controller state encoding.
package am2940_pkg;

  typedef enum logic [2:0] {
    WR_CR  = 3'd0,
    RD_CR  = 3'd1,
    RD_WC  = 3'd2,
    RD_AC  = 3'd3,
    REINIT = 3'd4,
    LD_AC  = 3'd5,
    LD_WC  = 3'd6,
    EN_CNT = 3'd7
  } am_instr_e;

  // Done modes held in CR[1:0]; CR[2] selects address decrement when set.
  localparam logic [1:0] DONE_WC_DEC   = 2'b00;
  localparam logic [1:0] DONE_WC_INC   = 2'b01;
  localparam logic [1:0] DONE_ADDR_CMP = 2'b10;
  localparam logic [1:0] DONE_NONE     = 2'b11;

  // Last beat index before an overrun is declared (256 acked beats).
  localparam logic [8:0] BEAT_LAST = 9'd255;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WCR,
    S_LDA,
    S_LDW,
    S_RUN,
    S_RDBK,
    S_FIN,
    S_REINIT
  } ctrl_state_e;

endpackage

// File: rtl/am2940_dma_ctrl_if.sv
// AM2940 instruction bus plus memory-beat handshake. The controller drives the
// master side; the AM2940 and memory responder sit on the slave side.
interface am2940_dma_ctrl_if;
  import am2940_pkg::*;

  am_instr_e   am_i;
  logic [7:0]  am_din;
  logic [7:0]  am_dout;
  logic [7:0]  am_addr;
  logic        am_done;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack;

  modport master (
    output am_i, am_din, mem_req, mem_addr,
    input  am_dout, am_addr, am_done, mem_ack
  );

  modport slave (
    input  am_i, am_din, mem_req, mem_addr,
    output am_dout, am_addr, am_done, mem_ack
  );

endinterface

// File: rtl/am2940_dma_ctrl.sv
// Sequencing master for the AM2940: programs CR/AC/WC, steps one count per
// acked memory beat, reads WC back. `AM2940_DMA_REPEAT_EN adds repeat passes.
module am2940_dma_ctrl
  import am2940_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
`ifdef AM2940_DMA_REPEAT_EN
  input  logic       repeat_mode,
`endif
  input  logic [2:0] cmd,
  input  logic [7:0] start_addr,
  input  logic [7:0] word_cnt,
  output logic       busy,
  output logic       fin,
  output logic       err,
  output logic [7:0] wc_status,
  am2940_dma_ctrl_if.master bus
);

  ctrl_state_e state_q, state_d;
  logic [2:0]  cmd_q, cmd_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  wc_q, wc_d;
  logic [7:0]  wc_status_q, wc_status_d;
  logic        err_q, err_d;
  logic [8:0]  beat_q, beat_d;
`ifdef AM2940_DMA_REPEAT_EN
  logic        repeat_q, repeat_d;
`endif

  // NOTE: reset is synchronous and every flop uses <= so all state updates
  // together at the edge, independent of evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      addr_q      <= '0;
      wc_q        <= '0;
      wc_status_q <= '0;
      err_q       <= 1'b0;
      beat_q      <= '0;
`ifdef AM2940_DMA_REPEAT_EN
      repeat_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      wc_q        <= wc_d;
      wc_status_q <= wc_status_d;
      err_q       <= err_d;
      beat_q      <= beat_d;
`ifdef AM2940_DMA_REPEAT_EN
      repeat_q    <= repeat_d;
`endif
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    wc_d        = wc_q;
    wc_status_d = wc_status_q;
    err_d       = err_q;
    beat_d      = beat_q;
`ifdef AM2940_DMA_REPEAT_EN
    repeat_d    = repeat_q;
`endif
    bus.am_i    = RD_AC;
    bus.am_din  = '0;
    bus.mem_req = 1'b0;
    fin         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cmd_d   = cmd;
          addr_d  = start_addr;
          wc_d    = word_cnt;
          err_d   = 1'b0;
          beat_d  = '0;
`ifdef AM2940_DMA_REPEAT_EN
          repeat_d = repeat_mode;
`endif
          state_d = S_WCR;
        end
      end
      S_WCR: begin
        bus.am_i   = WR_CR;
        bus.am_din = {5'b0, cmd_q};
        state_d    = S_LDA;
      end
      S_LDA: begin
        bus.am_i   = LD_AC;
        bus.am_din = addr_q;
        state_d    = S_LDW;
      end
      S_LDW: begin
        bus.am_i   = LD_WC;
        bus.am_din = wc_q;
        state_d    = S_RUN;
      end
      S_RUN: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ack) begin
          // Counters advance on the same edge that completes the beat.
          bus.am_i = EN_CNT;
          beat_d   = beat_q + 9'd1;
          if (bus.am_done) begin
            state_d = S_RDBK;
          end else if (beat_q == BEAT_LAST) begin
            err_d   = 1'b1;
            state_d = S_RDBK;
          end
        end
      end
      S_RDBK: begin
        bus.am_i    = RD_WC;
        wc_status_d = bus.am_dout;
        state_d     = S_FIN;
      end
      S_FIN: begin
        fin     = 1'b1;
        state_d = S_IDLE;
`ifdef AM2940_DMA_REPEAT_EN
        // The host keeps repeating by holding repeat_mode through each pass.
        repeat_d = repeat_mode;
        if (repeat_q) begin
          beat_d  = '0;
          state_d = S_REINIT;
        end
`endif
      end
`ifdef AM2940_DMA_REPEAT_EN
      S_REINIT: begin
        bus.am_i = REINIT;
        state_d  = S_RUN;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign busy         = (state_q != S_IDLE);
  assign err          = err_q;
  assign wc_status    = wc_status_q;
  assign bus.mem_addr = bus.am_addr;

endmodule

// File: tb/tb_am2940_dma_ctrl.sv
// Bench for am2940_dma_ctrl with a behavioural AM2940 (decrementing word-count
// mode only) and a memory responder; expected per-cycle traces come from a planner.
module tb_am2940_dma_ctrl;
  import am2940_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [2:0] cmd = '0;
  logic [7:0] start_addr = '0;
  logic [7:0] word_cnt = '0;
`ifdef AM2940_DMA_REPEAT_EN
  logic       repeat_mode = 1'b0;
`endif
  logic       busy, fin, err;
  logic [7:0] wc_status;

  am2940_dma_ctrl_if bus();

  am2940_dma_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
`ifdef AM2940_DMA_REPEAT_EN
    .repeat_mode(repeat_mode),
`endif
    .cmd        (cmd),
    .start_addr (start_addr),
    .word_cnt   (word_cnt),
    .busy       (busy),
    .fin        (fin),
    .err        (err),
    .wc_status  (wc_status),
    .bus        (bus.master)
  );

  always #5 clk = ~clk;

  // AM2940 behavioural model; its registers are never reset.
  logic [2:0] cr = '0;
  logic [7:0] ar = '0, wr = '0, ac = '0, wcn = '0;
  logic       done_kill = 1'b0;

  always @(posedge clk) begin
    case (bus.am_i)
      WR_CR:  cr <= bus.am_din[2:0];
      LD_AC:  begin ar <= bus.am_din; ac <= bus.am_din; end
      LD_WC:  begin wr <= bus.am_din; wcn <= bus.am_din; end
      REINIT: begin ac <= ar; wcn <= wr; end
      EN_CNT: begin
        ac <= cr[2] ? ac - 8'd1 : ac + 8'd1;
        if (cr[1:0] == DONE_WC_DEC) wcn <= wcn - 8'd1;
      end
      default: ;
    endcase
  end

  assign bus.am_addr = ac;
  assign bus.am_dout = (bus.am_i == RD_CR) ? {5'b0, cr} :
                       (bus.am_i == RD_WC) ? wcn : ac;
  assign bus.am_done = !done_kill && (cr[1:0] == DONE_WC_DEC) && (wcn == 8'd1);

  // Memory responder: acks the last cycle of every 'period' requesting cycles.
  int   period = 1;
  int   run_cnt = 0;
  logic force_ack = 1'b0;

  always @(posedge clk) run_cnt <= bus.mem_req ? run_cnt + 1 : 0;
  assign bus.mem_ack = force_ack | (bus.mem_req & ((run_cnt % period) == (period - 1)));

  // Expected per-cycle observation.
  typedef struct {
    logic [2:0] am_i;
    logic [7:0] am_din;
    logic       mem_req;
    logic       fin;
    logic       busy;
    logic       err;
    logic [7:0] wc;
    logic       chk_addr;
    logic [7:0] addr;
  } exp_t;

  exp_t       q[$];
  logic       m_err = 1'b0;
  logic [7:0] m_wc = '0;
  logic       cmp_en = 1'b0;
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [2:0] i, input logic [7:0] din, input logic req,
                              input logic f, input logic b, input logic e,
                              input logic [7:0] w, input logic ca, input logic [7:0] ad);
    exp_t r;
    r.am_i = i; r.am_din = din; r.mem_req = req; r.fin = f; r.busy = b;
    r.err = e; r.wc = w; r.chk_addr = ca; r.addr = ad;
    return r;
  endfunction

  // Plans the whole transfer from the descriptor: one idle cycle with start
  // high, three programming cycles, run cycles by the ack pattern, RDBK, FIN.
  task automatic plan(input logic [2:0] c, input logic [7:0] a, input logic [7:0] n,
                      input int p, input bit ovr, input bit rpt);
    logic       e = 1'b0;
    logic [7:0] w = m_wc;
    q.push_back(mk(3'd3, 8'h00, 0, 0, 0, m_err, w, 0, 8'h00));
    q.push_back(mk(3'd0, {5'b0, c}, 0, 0, 1, e, w, 0, 8'h00));
    q.push_back(mk(3'd5, a, 0, 0, 1, e, w, 0, 8'h00));
    q.push_back(mk(3'd6, n, 0, 0, 1, e, w, 0, 8'h00));
    for (int pass = 0; pass < (rpt ? 2 : 1); pass++) begin
      int k = 0;
      int cyc = 0;
      bit last = 0;
      if (pass > 0) q.push_back(mk(3'd4, 8'h00, 0, 0, 1, e, w, 0, 8'h00));
      while (!last) begin
        if ((cyc % p) == (p - 1)) begin
          logic [7:0] ad = c[2] ? a - 8'(k) : a + 8'(k);
          q.push_back(mk(3'd7, 8'h00, 1, 0, 1, e, w, 1, ad));
          k++;
          if (!ovr && k == int'(n)) last = 1;
          else if (k == 256) begin last = 1; e = 1'b1; end
        end else begin
          q.push_back(mk(3'd3, 8'h00, 1, 0, 1, e, w, 0, 8'h00));
        end
        cyc++;
      end
      q.push_back(mk(3'd2, 8'h00, 0, 0, 1, e, w, 0, 8'h00));
      w = n - 8'(k);
      q.push_back(mk(3'd3, 8'h00, 0, 1, 1, e, w, 0, 8'h00));
    end
  endtask

  // Single compare process: every cycle, against the plan or the idle state.
  always @(negedge clk) begin
    if (cmp_en) begin
      exp_t e;
      if (q.size() > 0) e = q.pop_front();
      else e = mk(3'd3, 8'h00, 0, 0, 0, m_err, m_wc, 0, 8'h00);
      m_err = e.err;
      m_wc  = e.wc;
      check("busy", 32'(busy), 32'(e.busy));
      check("am_i", 32'(bus.am_i), 32'(e.am_i));
      check("am_din", 32'(bus.am_din), 32'(e.am_din));
      check("mem_req", 32'(bus.mem_req), 32'(e.mem_req));
      check("fin", 32'(fin), 32'(e.fin));
      check("err", 32'(err), 32'(e.err));
      check("wc_status", 32'(wc_status), 32'(e.wc));
      check("mem_addr_pass", 32'(bus.mem_addr), 32'(ac));
      if (e.chk_addr) check("beat_addr", 32'(bus.mem_addr), 32'(e.addr));
    end
  end

  // Called at posedge+1; returns at posedge+1 once the plan is consumed.
  task automatic xfer(input logic [2:0] c, input logic [7:0] a, input logic [7:0] n,
                      input int p, input bit ovr, input bit rpt, input int poke);
    int t = 0;
    period = p;
    done_kill = ovr;
    plan(c, a, n, p, ovr, rpt);
    cmd = c; start_addr = a; word_cnt = n; start = 1'b1;
`ifdef AM2940_DMA_REPEAT_EN
    repeat_mode = rpt;
`endif
    @(posedge clk); #1;
    start = 1'b0;
`ifdef AM2940_DMA_REPEAT_EN
    repeat_mode = 1'b0;
`endif
    while (q.size() > 0 && t < 3000) begin
      @(posedge clk); #1;
      t++;
      if (poke != 0 && t == poke) begin start = 1'b1; start_addr = 8'hAA; cmd = 3'b111; end
      if (poke != 0 && t == poke + 1) start = 1'b0;
    end
    check("xfer_completes", 32'(q.size()), 32'd0);
    q.delete();
    done_kill = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_am_i", 32'(bus.am_i), 32'd3);
    check("rst_wc_status", 32'(wc_status), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic transfer, one beat per clock.
    xfer(3'b000, 8'h40, 8'd4, 1, 0, 0, 0);
    check("basic_end_addr", 32'(bus.am_addr), 32'h44);
    check("basic_wc_status", 32'(wc_status), 32'h00);
    check("basic_err", 32'(err), 32'd0);

    // Backpressure: ack every third requesting cycle.
    xfer(3'b000, 8'h40, 8'd4, 3, 0, 0, 0);
    check("bp_end_addr", 32'(bus.am_addr), 32'h44);
    check("bp_wc_status", 32'(wc_status), 32'h00);

    // Descending addresses, ack every other cycle.
    xfer(3'b100, 8'h10, 8'd3, 2, 0, 0, 0);
    check("desc_end_addr", 32'(bus.am_addr), 32'h0D);

    // mem_ack while idle must not count.
    force_ack = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("idle_ack_am_i", 32'(bus.am_i), 32'd3);
    @(posedge clk); #1;
    force_ack = 1'b0;
    check("idle_ack_addr", 32'(bus.am_addr), 32'h0D);

    // Overrun: done never rises, 256 beats then err.
    xfer(3'b000, 8'h40, 8'd4, 1, 1, 0, 0);
    check("ovr_err", 32'(err), 32'd1);
    check("ovr_wc_status", 32'(wc_status), 32'h04);
    check("ovr_busy", 32'(busy), 32'd0);
    check("ovr_end_addr", 32'(bus.am_addr), 32'h40);

    // Reset after two acked beats.
    period = 1;
    plan(3'b000, 8'h40, 8'd4, 1, 0, 0);
    cmd = 3'b000; start_addr = 8'h40; word_cnt = 8'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    q.delete();
    m_err = 1'b0;
    m_wc  = 8'h00;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("mid_rst_wc_status", 32'(wc_status), 32'd0);
    check("mid_rst_am_i", 32'(bus.am_i), 32'd3);
    @(posedge clk); #1;

    // Start coincident with reset is dropped.
    reset = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    check("start_in_reset_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // Clean run after reset, with a stray start pulse during RUN.
    xfer(3'b000, 8'h20, 8'd6, 1, 0, 0, 5);
    check("poke_end_addr", 32'(bus.am_addr), 32'h26);
    check("poke_err", 32'(err), 32'd0);

`ifdef AM2940_DMA_REPEAT_EN
    // Two passes over the same addresses.
    xfer(3'b000, 8'h60, 8'd2, 1, 0, 1, 0);
    check("rpt_busy", 32'(busy), 32'd0);
    check("rpt_end_addr", 32'(bus.am_addr), 32'h62);
`endif

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
